// File: rtl/exc_check_stage.sv
// exc_check_stage: decodes syscall/break/trap exceptions, merges them with upstream codes, and registers the result with a saturating trap counter.
module exc_check_stage #(
  parameter int DW      = 32,
  parameter bit TRAP_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [31:0]      instr_in,
  input  logic [DW-1:0]    rd1,
  input  logic [DW-1:0]    rd2,
  input  logic [4:0]       exc_in,
  output logic             valid_out,
  output logic [4:0]       exc_out,
  output logic             exc_pending,
  output logic [CNT_W-1:0] trap_cnt
);
  logic [5:0] op, fn;
  logic [4:0] rt;
  logic special, regimm, is_sys, is_brk;
  logic t_ge, t_geu, t_lt, t_ltu, t_eq, t_ne, is_trap, cond;
  logic [DW-1:0] imm, opb;
  logic [4:0] local_exc, next_exc;
  logic valid_q;
  logic [4:0] exc_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic unused_rs;
  assign unused_rs = ^instr_in[25:21];
  always_comb begin
    op        = instr_in[31:26];
    fn        = instr_in[5:0];
    rt        = instr_in[20:16];
    special   = op == 6'h00;
    regimm    = op == 6'h01;
    is_sys    = special & (fn == 6'h0c);
    is_brk    = special & (fn == 6'h0d);
    t_ge      = special ? fn == 6'h30 : regimm & (rt == 5'h08);
    t_geu     = special ? fn == 6'h31 : regimm & (rt == 5'h09);
    t_lt      = special ? fn == 6'h32 : regimm & (rt == 5'h0a);
    t_ltu     = special ? fn == 6'h33 : regimm & (rt == 5'h0b);
    t_eq      = special ? fn == 6'h34 : regimm & (rt == 5'h0c);
    t_ne      = special ? fn == 6'h36 : regimm & (rt == 5'h0e);
    is_trap   = t_ge | t_geu | t_lt | t_ltu | t_eq | t_ne;
    imm       = DW'($signed(instr_in[15:0]));
    opb       = special ? rd2 : imm;
    cond      = (t_ge  & ($signed(rd1) >= $signed(opb))) |
                (t_geu & (rd1 >= opb)) |
                (t_lt  & ($signed(rd1) <  $signed(opb))) |
                (t_ltu & (rd1 <  opb)) |
                (t_eq  & (rd1 == opb)) |
                (t_ne  & (rd1 != opb));
    local_exc = is_sys ? 5'd8 : is_brk ? 5'd9 : (is_trap & !TRAP_EN) ? 5'd10 :
                (is_trap & cond) ? 5'd13 : 5'd0;
    next_exc  = (exc_in != 5'd0) ? exc_in : local_exc;
    // counter saturates instead of wrapping so a long debug run never reads back small
    cnt_d     = (valid_in && next_exc == 5'd13 && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      exc_q   <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      exc_q   <= '0;
    end else if (!stall) begin
      valid_q <= valid_in;
      exc_q   <= valid_in ? next_exc : 5'd0;
      cnt_q   <= cnt_d;
    end
  end
  assign valid_out   = valid_q;
  assign exc_out     = exc_q;
  assign exc_pending = valid_q & (exc_q != 5'd0);
  assign trap_cnt    = cnt_q;
endmodule

// File: tb/tb_exc_check_stage.sv
// tb_exc_check_stage: three parameterisations driven in lockstep, checked every cycle against a behavioural model plus directed literals.
module tb_exc_check_stage;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [31:0] instr_in = '0, rd1 = '0, rd2 = '0;
  logic [4:0] exc_in = '0;
  logic v0, v1, v2, p0, p1, p2;
  logic [4:0] e0, e1, e2;
  logic [15:0] c0, c1;
  logic [1:0] c2;
  int ntests = 0, nfail = 0;
  bit mon = 1'b0;
  bit mv[3];
  logic [4:0] me[3];
  int mc[3];
  int cmax[3] = '{65535, 65535, 3};
  bit ten[3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  exc_check_stage u0 (.clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .instr_in(instr_in), .rd1(rd1), .rd2(rd2), .exc_in(exc_in), .valid_out(v0), .exc_out(e0),
    .exc_pending(p0), .trap_cnt(c0));
  exc_check_stage #(.TRAP_EN(1'b0)) u1 (.clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .instr_in(instr_in), .rd1(rd1), .rd2(rd2), .exc_in(exc_in), .valid_out(v1),
    .exc_out(e1), .exc_pending(p1), .trap_cnt(c1));
  exc_check_stage #(.CNT_W(2)) u2 (.clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .instr_in(instr_in), .rd1(rd1), .rd2(rd2), .exc_in(exc_in), .valid_out(v2),
    .exc_out(e2), .exc_pending(p2), .trap_cnt(c2));

  function automatic logic [31:0] sp(logic [5:0] f);
    return {6'd0, 5'd3, 5'd4, 10'd0, f};
  endfunction

  function automatic logic [31:0] ri(logic [4:0] r, logic [15:0] i);
    return {6'd1, 5'd3, r, i};
  endfunction

  function automatic logic [4:0] local_code(logic [31:0] ins, logic [31:0] a, logic [31:0] b, bit te);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    logic [4:0] rt = ins[20:16];
    logic [31:0] imm = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] ub = (op == 6'd0) ? b : imm;
    int sa = a;
    int sb = ub;
    bit trap = 1'b0, hit = 1'b0;
    if (op == 6'd0) begin
      case (fn)
        6'h0c: return 5'd8;
        6'h0d: return 5'd9;
        6'h30: begin trap = 1; hit = sa >= sb; end
        6'h31: begin trap = 1; hit = a >= ub; end
        6'h32: begin trap = 1; hit = sa < sb; end
        6'h33: begin trap = 1; hit = a < ub; end
        6'h34: begin trap = 1; hit = a == ub; end
        6'h36: begin trap = 1; hit = a != ub; end
        default: ;
      endcase
    end else if (op == 6'd1) begin
      case (rt)
        5'h08: begin trap = 1; hit = sa >= sb; end
        5'h09: begin trap = 1; hit = a >= ub; end
        5'h0a: begin trap = 1; hit = sa < sb; end
        5'h0b: begin trap = 1; hit = a < ub; end
        5'h0c: begin trap = 1; hit = a == ub; end
        5'h0e: begin trap = 1; hit = a != ub; end
        default: ;
      endcase
    end
    if (!trap) return 5'd0;
    if (!te) return 5'd10;
    return hit ? 5'd13 : 5'd0;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      automatic logic [4:0] nx = (exc_in != 0) ? exc_in : local_code(instr_in, rd1, rd2, ten[i]);
      if (reset) begin
        mv[i] = 0; me[i] = 0; mc[i] = 0;
      end else if (flush) begin
        mv[i] = 0; me[i] = 0;
      end else if (!stall) begin
        mv[i] = valid_in;
        me[i] = valid_in ? nx : 5'd0;
        if (valid_in && nx == 5'd13 && mc[i] < cmax[i]) mc[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      chk("m_v0", v0, mv[0]); chk("m_e0", e0, me[0]); chk("m_p0", p0, mv[0] && me[0] != 0); chk("m_c0", c0, mc[0]);
      chk("m_v1", v1, mv[1]); chk("m_e1", e1, me[1]); chk("m_p1", p1, mv[1] && me[1] != 0); chk("m_c1", c1, mc[1]);
      chk("m_v2", v2, mv[2]); chk("m_e2", e2, me[2]); chk("m_p2", p2, mv[2] && me[2] != 0); chk("m_c2", c2, mc[2]);
    end
  end

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] e = 5'd0, input bit st = 0, input bit fl = 0, input bit rs = 0);
    reset = rs; valid_in = v; instr_in = ins; rd1 = a; rd2 = b; exc_in = e; stall = st; flush = fl;
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] fns[8] = '{6'h0c, 6'h0d, 6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h36};
    logic [4:0] rts[7] = '{5'h08, 5'h09, 5'h0a, 5'h0b, 5'h0c, 5'h0e, 5'h0d};
    int cexp[5] = '{1, 2, 3, 3, 3};
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_v", v0, 0); chk("rst_e", e0, 0); chk("rst_c", c0, 0);
    mon = 1;
    drive(1, sp(6'h34), 32'h1234, 32'h1234);
    chk("teq_e", e0, 13); chk("teq_p", p0, 1); chk("teq_c", c0, 1);
    chk("teq_ri", e1, 10); chk("teq_ri_c", c1, 0);
    drive(1, sp(6'h32), 5, 5);                 chk("tlt_eq", e0, 0);
    drive(1, sp(6'h32), 32'hffffffff, 1);      chk("tlt_neg", e0, 13);
    drive(1, sp(6'h33), 32'hffffffff, 1);      chk("tltu", e0, 0);
    drive(1, sp(6'h0c), 0, 0, 5'd4);           chk("sys_up", e0, 4);
    drive(1, sp(6'h0c), 0, 0);                 chk("sys", e0, 8);
    drive(1, sp(6'h0d), 0, 0);                 chk("brk", e0, 9);
    drive(0, sp(6'h0c), 0, 0, 5'd4);           chk("bub_e", e0, 0); chk("bub_v", v0, 0);
    drive(1, sp(6'h34), 7, 7);                 chk("ld13", e0, 13); chk("ld13_c", c0, 3);
    repeat (3) begin
      drive(1, sp(6'h0d), 0, 0, 0, 1);
      chk("stall_e", e0, 13); chk("stall_c", c0, 3);
    end
    drive(1, sp(6'h0d), 0, 0, 0, 1, 1);        chk("fl_e", e0, 0); chk("fl_v", v0, 0);
    drive(1, ri(5'h0c, 16'h0005), 5, 0);       chk("teqi_ri", e1, 10); chk("teqi_ri_c", c1, 0); chk("teqi", e0, 13);
    drive(1, ri(5'h09, 16'hffff), 32'hfffffff0, 0); chk("tgeiu", e0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, sp(6'h36), 1, 2);
      chk("sat_c", c2, cexp[i]);
    end
    drive(1, sp(6'h36), 1, 2, 0, 0, 0, 1);     chk("rst_c2", c2, 0); chk("rst_e2", e2, 0);
    for (int n = 0; n < 3000; n++) begin
      automatic int k = $urandom_range(0, 15);
      automatic logic [31:0] ins = (k < 8) ? sp(fns[k]) : (k < 15) ? ri(rts[k - 8], 16'($urandom)) : $urandom;
      automatic logic [31:0] a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      automatic logic [31:0] b = $urandom_range(0, 2) == 0 ? a : $urandom;
      automatic logic [4:0] e = 0;
      if (k >= 8 && $urandom_range(0, 2) == 0) a = {{16{ins[15]}}, ins[15:0]} + 32'($urandom_range(0, 2)) - 1;
      if ($urandom_range(0, 7) == 0) e = ($urandom_range(0, 1) == 1) ? 5'd13 : 5'($urandom);
      drive($urandom_range(0, 3) != 0, ins, a, b, e, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
